// File: rtl/truth_table_pkg.sv
// Shared types and constants for the truth table capture unit.
// Imported by the capture stage and the top level.
package truth_table_pkg;

  localparam int X_W = 3;
  localparam int ENTRIES = 8;
  localparam int COUNT_MAX = 255;
  localparam logic [ENTRIES-1:0] EXPECTED_DEFAULT = 8'b01100001;

  typedef enum logic [1:0] {
    EMPTY,
    FILLING,
    FULL,
    ERROR
  } state_t;

endpackage

// File: rtl/truth_table_capture_stage.sv
// Stage-1 sample register for truth_table_capture.
// A clear flushes the held sample and drops the incoming one.
module capture_stage
  import truth_table_pkg::*;
(
  input  logic           clock,
  input  logic           reset_n,
  input  logic           clear,
  input  logic           sample_valid,
  input  logic [X_W-1:0] x,
  input  logic           z,
  output logic           s1_valid,
  output logic [X_W-1:0] s1_x,
  output logic           s1_z
);

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      s1_valid <= 1'b0;
      s1_x     <= '0;
      s1_z     <= 1'b0;
    end else if (clear) begin
      s1_valid <= 1'b0;
      s1_x     <= '0;
      s1_z     <= 1'b0;
    end else begin
      s1_valid <= sample_valid;
      s1_x     <= x;
      s1_z     <= z;
    end
  end

endmodule

// File: rtl/truth_table_capture.sv
// Captures an observed 3-input function into a truth table,
// flags contradictions and compares against a reference.
module truth_table_capture
  import truth_table_pkg::*;
#(
  parameter logic [ENTRIES-1:0] EXPECTED = EXPECTED_DEFAULT
) (
  input  logic               clock,
  input  logic               reset_n,
  input  logic               clear,
  input  logic               sample_valid,
  input  logic [X_W-1:0]     x,
  input  logic               z,
  output logic [ENTRIES-1:0] table_bits,
  output logic [ENTRIES-1:0] known,
  output logic               complete,
  output logic               match,
  output logic               conflict,
  output logic [X_W-1:0]     conflict_idx,
  output logic [7:0]         sample_count
);

  logic           s1_valid;
  logic [X_W-1:0] s1_x;
  logic           s1_z;

  capture_stage u_capture (
    .clock       (clock),
    .reset_n     (reset_n),
    .clear       (clear),
    .sample_valid(sample_valid),
    .x           (x),
    .z           (z),
    .s1_valid    (s1_valid),
    .s1_x        (s1_x),
    .s1_z        (s1_z)
  );

  state_t state, state_nxt;

  logic               contra;
  logic [ENTRIES-1:0] tbl_nxt;
  logic [ENTRIES-1:0] known_nxt;
  logic               conflict_nxt;
  logic [X_W-1:0]     idx_nxt;
  logic [7:0]         count_nxt;
  logic               complete_nxt;
  logic               match_nxt;

  assign contra = s1_valid && known[s1_x]
               && (table_bits[s1_x] != s1_z);

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n)   state <= EMPTY;
    else if (clear) state <= EMPTY;
    else            state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    unique case (state)
      EMPTY:   if (s1_valid) state_nxt = FILLING;
      FILLING: begin
        if (contra)              state_nxt = ERROR;
        else if (&known_nxt)     state_nxt = FULL;
      end
      FULL:    if (contra) state_nxt = ERROR;
      ERROR:   state_nxt = ERROR;
      default: state_nxt = EMPTY;
    endcase
  end

  // ERROR freezes the table; only the counter keeps moving
  always_comb begin
    tbl_nxt      = table_bits;
    known_nxt    = known;
    conflict_nxt = conflict;
    idx_nxt      = conflict_idx;
    count_nxt    = sample_count;
    if (s1_valid) begin
      if (sample_count != 8'(COUNT_MAX))
        count_nxt = sample_count + 8'd1;
      if (state != ERROR) begin
        if (!known[s1_x]) begin
          tbl_nxt[s1_x]   = s1_z;
          known_nxt[s1_x] = 1'b1;
        end else if (contra) begin
          conflict_nxt = 1'b1;
          idx_nxt      = s1_x;
        end
      end
    end
    complete_nxt = (&known_nxt) && !conflict_nxt;
    match_nxt    = complete_nxt && (tbl_nxt == EXPECTED);
  end

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n || clear) begin
      table_bits   <= '0;
      known        <= '0;
      complete     <= 1'b0;
      match        <= 1'b0;
      conflict     <= 1'b0;
      conflict_idx <= '0;
      sample_count <= '0;
    end else begin
      table_bits   <= tbl_nxt;
      known        <= known_nxt;
      complete     <= complete_nxt;
      match        <= match_nxt;
      conflict     <= conflict_nxt;
      conflict_idx <= idx_nxt;
      sample_count <= count_nxt;
    end
  end

endmodule

// File: tb/tb_truth_table_capture.sv
// Directed and random checks of truth_table_capture
// against a sample-level reference model.
module tb_truth_table_capture;

  localparam logic [7:0] EXP = 8'b01100001;

  logic       clock = 1'b0;
  logic       reset_n = 1'b0;
  logic       clear = 1'b0;
  logic       sample_valid = 1'b0;
  logic [2:0] x = '0;
  logic       z = 1'b0;
  logic [7:0] table_bits;
  logic [7:0] known;
  logic       complete;
  logic       match;
  logic       conflict;
  logic [2:0] conflict_idx;
  logic [7:0] sample_count;

  int checks = 0;
  int errors = 0;

  truth_table_capture #(.EXPECTED(EXP)) dut (
    .clock       (clock),
    .reset_n     (reset_n),
    .clear       (clear),
    .sample_valid(sample_valid),
    .x           (x),
    .z           (z),
    .table_bits  (table_bits),
    .known       (known),
    .complete    (complete),
    .match       (match),
    .conflict    (conflict),
    .conflict_idx(conflict_idx),
    .sample_count(sample_count)
  );

  always #5 clock = ~clock;

  // reference model: a list of seen entries plus one in-flight sample
  bit m_val[8];
  bit m_seen[8];
  bit m_conf;
  int m_idx;
  int m_cnt;
  bit p_v;
  int p_x;
  bit p_z;
  bit exp_bit[8];

  function automatic void m_reset();
    for (int i = 0; i < 8; i++) begin
      m_val[i] = 0;
      m_seen[i] = 0;
    end
    m_conf = 0;
    m_idx = 0;
    m_cnt = 0;
    p_v = 0;
  endfunction

  function automatic void m_apply(int ix, bit iz);
    m_cnt = (m_cnt + 1 > 255) ? 255 : m_cnt + 1;
    if (m_conf) return;
    if (!m_seen[ix]) begin
      m_seen[ix] = 1;
      m_val[ix] = iz;
    end else if (m_val[ix] != iz) begin
      m_conf = 1;
      m_idx = ix;
    end
  endfunction

  function automatic logic [7:0] pack(bit a[8]);
    logic [7:0] r;
    for (int i = 0; i < 8; i++) r[i] = a[i];
    return r;
  endfunction

  function automatic bit m_complete();
    int n = 0;
    for (int i = 0; i < 8; i++) n += m_seen[i];
    return (n == 8) && !m_conf;
  endfunction

  function automatic bit m_match();
    if (!m_complete()) return 0;
    for (int i = 0; i < 8; i++)
      if (m_val[i] != exp_bit[i]) return 0;
    return 1;
  endfunction

  task automatic chk(string tag, logic [7:0] obs, logic [7:0] e);
    checks++;
    assert (obs === e) else begin
      errors++;
      $error("FAIL %s observed %0h expected %0h", tag, obs, e);
    end
  endtask

  task automatic chk_all(string tag);
    chk({tag, ".table"}, table_bits, pack(m_val));
    chk({tag, ".known"}, known, pack(m_seen));
    chk({tag, ".complete"}, 8'(complete), 8'(m_complete()));
    chk({tag, ".match"}, 8'(match), 8'(m_match()));
    chk({tag, ".conflict"}, 8'(conflict), 8'(m_conf));
    chk({tag, ".cidx"}, 8'(conflict_idx), 8'(m_idx));
    chk({tag, ".count"}, sample_count, 8'(m_cnt));
  endtask

  task automatic cyc(bit v, int ix, bit iz, bit clr, string tag);
    @(negedge clock);
    sample_valid = v;
    x = 3'(ix);
    z = iz;
    clear = clr;
    @(posedge clock);
    #1;
    if (clr) begin
      m_reset();
    end else begin
      if (p_v) m_apply(p_x, p_z);
      p_v = v;
      p_x = ix;
      p_z = iz;
    end
    chk_all(tag);
  endtask

  task automatic idle(int n, string tag);
    for (int i = 0; i < n; i++) cyc(0, 0, 0, 0, tag);
  endtask

  initial begin
    for (int i = 0; i < 8; i++) exp_bit[i] = EXP[i];
    m_reset();
    #12;
    chk_all("reset");
    reset_n = 1'b1;

    for (int i = 0; i < 8; i++) cyc(1, i, exp_bit[i], 0, "sweep");
    idle(1, "sweep_drain");
    chk("sweep.table61", table_bits, 8'h61);
    chk("sweep.knownFF", known, 8'hFF);
    chk("sweep.match", 8'(match), 8'd1);
    chk("sweep.count8", sample_count, 8'd8);

    cyc(0, 0, 0, 1, "clr1");
    cyc(1, 5, 1, 0, "conf_a");
    cyc(1, 5, 0, 0, "conf_b");
    cyc(1, 0, 1, 0, "conf_c");
    idle(2, "conf_drain");
    chk("conf.flag", 8'(conflict), 8'd1);
    chk("conf.idx5", 8'(conflict_idx), 8'd5);
    chk("conf.known20", known, 8'h20);
    chk("conf.count3", sample_count, 8'd3);

    cyc(0, 0, 0, 1, "clr2");
    for (int i = 0; i < 8; i++) cyc(1, i, !exp_bit[i], 0, "inv");
    idle(1, "inv_drain");
    chk("inv.table9E", table_bits, 8'h9E);
    chk("inv.complete", 8'(complete), 8'd1);
    chk("inv.nomatch", 8'(match), 8'd0);

    cyc(0, 0, 0, 1, "clr3");
    for (int i = 0; i < 4; i++) cyc(1, i, exp_bit[i], 0, "pre_clr");
    cyc(1, 3, 1, 1, "clr_win");
    chk("clrwin.known0", known, 8'h00);
    idle(2, "clr_after");
    chk("clrwin.known3", 8'(known[3]), 8'd0);

    for (int i = 0; i < 4; i++) cyc(1, i + 2, exp_bit[i + 2], 0, "pre_rst");
    @(negedge clock);
    sample_valid = 1'b0;
    #2;
    reset_n = 1'b0;
    #1;
    m_reset();
    chk_all("async_rst");
    #3;
    reset_n = 1'b1;
    cyc(1, 7, 1, 0, "post_rst_e1");
    chk("post_rst.e1known", known, 8'h00);
    cyc(0, 0, 0, 0, "post_rst_e2");
    chk("post_rst.e2known80", known, 8'h80);

    cyc(0, 0, 0, 1, "clr4");
    for (int i = 0; i < 8; i++) cyc(1, i, exp_bit[i], 0, "sat_sweep");
    for (int i = 0; i < 292; i++) begin
      int r = $urandom_range(0, 7);
      cyc(1, r, exp_bit[r], 0, "sat");
    end
    idle(3, "sat_drain");
    chk("sat.count255", sample_count, 8'd255);
    chk("sat.full", 8'(complete), 8'd1);
    chk("sat.noconf", 8'(conflict), 8'd0);

    for (int i = 0; i < 400; i++) begin
      bit v = ($urandom_range(0, 3) != 0);
      int r = $urandom_range(0, 7);
      bit zz = ($urandom_range(0, 9) == 0) ? !exp_bit[r] : exp_bit[r];
      bit c = ($urandom_range(0, 39) == 0);
      cyc(v, r, zz, c, "rand");
    end
    idle(2, "rand_drain");

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/truth_table_capture.md
TRUTH_TABLE_CAPTURE -- requirements
Module: truth_table_capture

Interface
REQ-001 Parameter: EXPECTED, default 8'b01100001, the reference 3-input function that the captured table is compared against.
REQ-002 clock  input  1  single clock; all state changes on its rising edge.
REQ-003 reset_n  input  1  asynchronous, active-low reset.
REQ-004 clear  input  1  synchronous clear of all captured state.
REQ-005 sample_valid  input  1  qualifies x/z this cycle.
REQ-006 x  input  3  input vector of the observed function (table index).
REQ-007 z  input  1  observed function output for x.
REQ-008 table  output  8  captured truth table; bit i = z seen for x=i.
REQ-009 known  output  8  bit i = entry i captured at least once.
REQ-010 complete  output  1  known == 8'hFF and no conflict.
REQ-011 match  output  1  complete and table == EXPECTED.
REQ-012 conflict  output  1  sticky; a sample contradicted a known entry.
REQ-013 conflict_idx  output  3  index of the first contradicting sample.
REQ-014 sample_count  output  8  applied samples, saturating at 255.

Function
REQ-015 Two-stage pipeline: stage 1 registers {sample_valid, x, z}; stage 2 applies the stage-1 sample to the table state. Outputs are updated at the second rising edge after the sample is presented.
REQ-016 The FSM SHALL have four states: EMPTY (known==0), FILLING, FULL (known==8'hFF), ERROR.
REQ-017 EMPTY->FILLING on the first applied sample; FILLING->FULL on the applied sample that sets the last known bit; a contradiction in any of EMPTY, FILLING or FULL goes to ERROR; ERROR is left only by clear or reset.
REQ-018 Applying a sample at index i with known[i]=0: table[i]<=z and known[i]<=1.
REQ-019 Applying a sample with known[i]=1 and table[i]==z: no change to table/known.
REQ-020 Applying a sample with known[i]=1 and table[i]!=z: conflict<=1, conflict_idx<=i, enter ERROR; table and known are not modified.
REQ-021 In ERROR, further samples do not modify table, known, conflict_idx or state; sample_count still increments.
REQ-022 sample_count increments once per applied stage-2 sample in every state and holds at 255.
REQ-023 complete and match are registered and derived from the post-update state, so they are valid in the same cycle as table and known.
REQ-024 clear asserted: stage 1 flushed, all outputs return to reset values at the next edge, state goes to EMPTY; the stage-1 sample in flight is discarded.
REQ-025 clear and sample_valid in the same cycle: clear wins and the sample is dropped.

Reset
REQ-026 While reset_n=0, asynchronously: table=0, known=0, complete=0, match=0, conflict=0, conflict_idx=0, sample_count=0, stage-1 valid=0, state=EMPTY.
REQ-027 Reset mid-sweep discards the stage-1 sample; the first sample after release sees a 2-edge latency.

Structure
REQ-028 Shared package truth_table_pkg: state enum {EMPTY, FILLING, FULL, ERROR}, X_W=3, ENTRIES=8, COUNT_MAX=255, EXPECTED_DEFAULT=8'b01100001.
REQ-029 One sub-module, capture_stage: the stage-1 register with clear/flush. The FSM, table and counter are in the top level.

Verification
REQ-030 Reset, then present x=0..7 with z=EXPECTED[x], one per cycle -> 2 edges after the 8th sample: table=8'h61, known=8'hFF, complete=1, match=1, sample_count=8.
REQ-031 Present x=5,z=1, then x=5,z=0 -> conflict=1, conflict_idx=5, table[5]=1, complete=0; a following x=0,z=1 leaves known unchanged and gives sample_count=3.
REQ-032 Present x=0..7 with z=~EXPECTED[x] -> table=8'h9E, complete=1, match=0, conflict=0.
REQ-033 Assert clear in the same cycle as sample_valid (x=3,z=1) after 4 prior samples -> all outputs 0 after the edge; known[3] stays 0.
REQ-034 Drop reset_n between clock edges after 4 samples -> outputs 0 immediately, before the next edge; after release, x=7,z=1 gives known=8'h80 at edge 2.
REQ-035 Apply 300 consistent samples -> sample_count=255 and holds; state=FULL; no conflict.
